// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit: command
// encodings, default sizes and the sequencer state encoding.
package exe_muldiv_pkg;

    // Default datapath sizing; the counter must be able to hold WIDTH-1.
    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    // EXE_CMD encodings. MUL/DIV occupy codes unused by the ALU.
    localparam logic [3:0] EXE_ADD   = 4'b0000;
    localparam logic [3:0] EXE_SUB   = 4'b0010;
    localparam logic [3:0] EXE_AND   = 4'b0100;
    localparam logic [3:0] EXE_OR    = 4'b0101;
    localparam logic [3:0] EXE_NOR   = 4'b0110;
    localparam logic [3:0] EXE_XOR   = 4'b0111;
    localparam logic [3:0] EXE_SLA   = 4'b1000;
    localparam logic [3:0] EXE_SRA   = 4'b1001;
    localparam logic [3:0] EXE_SRL   = 4'b1010;
    localparam logic [3:0] EXE_MUL   = 4'b1100;
    localparam logic [3:0] EXE_DIV   = 4'b1101;
    localparam logic [3:0] EXE_NO_OP = 4'b1111;

    // Sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    // True for the two commands this unit executes.
    function automatic logic is_md_cmd(input logic [3:0] cmd);
        return (cmd == EXE_MUL) || (cmd == EXE_DIV);
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_datapath.sv
// Iterative magnitude datapath: shift-add multiply (low word only) and
// restoring shift-subtract divide, one iteration per step pulse.
//   MUL: acc_q accumulates, sh_q is the multiplicand shifting left,
//        op_q is the multiplier shifting right.
//   DIV: acc_q is the partial remainder, sh_q shifts the dividend out at
//        the top while quotient bits shift in at the bottom, op_q is the
//        divisor.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             op_is_div,
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] res_mag,
    output logic [WIDTH-1:0] rem_mag
);

    logic [WIDTH-1:0] acc_q, sh_q, op_q;
    logic [WIDTH-1:0] acc_nxt, sh_nxt, op_nxt;
    logic [WIDTH:0]   part;
    logic [WIDTH+1:0] diff;

    // One iteration of the selected algorithm. The subtract is two bits
    // wider than the divisor so the borrow stays meaningful even for a
    // zero divisor, where the partial remainder can use all WIDTH bits.
    always_comb begin
        part    = {acc_q, sh_q[WIDTH-1]};
        diff    = {1'b0, part} - {2'b00, op_q};
        acc_nxt = acc_q;
        sh_nxt  = sh_q;
        op_nxt  = op_q;
        if (op_is_div) begin
            if (!diff[WIDTH+1]) begin
                acc_nxt = diff[WIDTH-1:0];
                sh_nxt  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = part[WIDTH-1:0];
                sh_nxt  = {sh_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (op_q[0]) begin
                acc_nxt = acc_q + sh_q;
            end
            sh_nxt = {sh_q[WIDTH-2:0], 1'b0};
            op_nxt = {1'b0, op_q[WIDTH-1:1]};
        end
    end

    // Operand load on launch, otherwise advance one iteration per step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            sh_q  <= '0;
            op_q  <= '0;
        end else if (load) begin
            acc_q <= '0;
            sh_q  <= a_mag;
            op_q  <= b_mag;
        end else if (step) begin
            acc_q <= acc_nxt;
            sh_q  <= sh_nxt;
            op_q  <= op_nxt;
        end
    end

    // Unsigned magnitudes of the finished operation.
    always_comb begin
        res_mag = op_is_div ? sh_q : acc_q;
        rem_mag = op_is_div ? acc_q : '0;
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// EXE-stage multi-cycle MUL/DIV unit. Launches from the ID/EXE register,
// stalls the front of the pipe for WIDTH+1 cycles, then presents a signed
// result for one cycle (DONE), during which the pipe advances.
// Handshake: a MUL/DIV command held in ID/EXE is accepted in IDLE when
// kill is low; stall stays high until the DONE cycle, and result_valid is
// a single-cycle pulse in DONE that consumers must use to qualify
// result/remainder. kill overrides everything in every state.
module exe_muldiv_unit
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       EXE_CMD,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             kill,
    output logic             stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             op_div_q, neg_res_q, neg_rem_q, dbz_q;
    logic [WIDTH-1:0] result_q, remainder_q;

    logic             is_md, launch, last_iter;
    logic             dp_load, dp_step;
    logic             cmd_div, b_zero;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] res_mag, rem_mag;
    logic [WIDTH-1:0] res_fixed, rem_fixed;

    // Command decode and operand magnitudes; reset masks the command so
    // nothing stalls while the unit is held in reset.
    always_comb begin
        is_md     = rst & is_md_cmd(EXE_CMD);
        launch    = is_md & ~kill;
        cmd_div   = (EXE_CMD == EXE_DIV);
        b_zero    = (val2 == '0);
        a_mag     = val1[WIDTH-1] ? (~val1 + 1'b1) : val1;
        b_mag     = val2[WIDTH-1] ? (~val2 + 1'b1) : val2;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; kill always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: state_d = launch ? MD_BUSY : MD_IDLE;
            MD_BUSY: begin
                if (kill) begin
                    state_d = MD_IDLE;
                end else if (last_iter) begin
                    state_d = MD_DONE;
                end else begin
                    state_d = MD_BUSY;
                end
            end
            MD_DONE: state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    // Per-state outputs and datapath controls.
    always_comb begin
        stall        = 1'b0;
        result_valid = 1'b0;
        dp_load      = 1'b0;
        dp_step      = 1'b0;
        case (state_q)
            MD_IDLE: begin
                stall   = launch;
                dp_load = launch;
            end
            MD_BUSY: begin
                stall   = ~kill;
                dp_step = ~kill;
            end
            MD_DONE: result_valid = ~kill;
            default: ;
        endcase
    end

    // Launch-time bookkeeping (op type, signs, divide-by-zero) and the
    // iteration counter. A zero divisor keeps the all-ones quotient by
    // suppressing quotient negation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
        end else if ((state_q == MD_IDLE) && launch) begin
            cnt_q     <= '0;
            op_div_q  <= cmd_div;
            neg_res_q <= (val1[WIDTH-1] ^ val2[WIDTH-1]) & ~(cmd_div & b_zero);
            neg_rem_q <= cmd_div & val1[WIDTH-1];
            dbz_q     <= cmd_div & b_zero;
        end else if ((state_q == MD_BUSY) && !kill) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sign correction of the magnitude results.
    always_comb begin
        res_fixed = neg_res_q ? (~res_mag + 1'b1) : res_mag;
        rem_fixed = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
    end

    // Hold the last delivered result so the outputs stay stable outside DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q    <= '0;
            remainder_q <= '0;
        end else if ((state_q == MD_DONE) && !kill) begin
            result_q    <= res_fixed;
            remainder_q <= rem_fixed;
        end
    end

    // Result presentation: live value in DONE, held value elsewhere.
    always_comb begin
        result      = (state_q == MD_DONE) ? res_fixed : result_q;
        remainder   = (state_q == MD_DONE) ? rem_fixed : remainder_q;
        div_by_zero = dbz_q;
        dbg_state   = state_q;
    end

    muldiv_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load      (dp_load),
        .step      (dp_step),
        .op_is_div (op_div_q),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .res_mag   (res_mag),
        .rem_mag   (rem_mag)
    );

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Bench for exe_muldiv_unit: pipeline-style driver that holds an
// instruction until a non-stalled edge, a reference model based on plain
// signed arithmetic, and a negedge monitor that pops expected results.
module tb_exe_muldiv_unit;
    import exe_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic [3:0]   EXE_CMD;
    logic [W-1:0] val1, val2;
    logic         kill;
    logic         stall, result_valid, div_by_zero;
    logic [W-1:0] result, remainder;
    logic [1:0]   dbg_state;

    int tests = 0;
    int fails = 0;
    int stall_run = 0;
    logic prev_rv = 1'b0;

    logic [W-1:0] exp_res_q[$];
    logic [W-1:0] exp_rem_q[$];
    logic [W-1:0] exp_dbz_q[$];

    exe_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .EXE_CMD      (EXE_CMD),
        .val1         (val1),
        .val2         (val2),
        .kill         (kill),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result),
        .remainder    (remainder),
        .div_by_zero  (div_by_zero),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // global time limit
    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: signed arithmetic with the unit's corner-case rules.
    function automatic void model(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [W-1:0] m, output logic [W-1:0] z);
        logic signed [W-1:0]   sa, sb;
        logic signed [2*W-1:0] xa, xb, p;
        sa = a;
        sb = b;
        xa = sa;
        xb = sb;
        z  = '0;
        if (cmd == EXE_MUL) begin
            p = xa * xb;
            r = p[W-1:0];
            m = '0;
        end else if (b == '0) begin
            r = '1;
            m = a;
            z = W'(1);
        end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
            r = {1'b1, {(W-1){1'b0}}};
            m = '0;
        end else begin
            r = sa / sb;
            m = sa % sb;
        end
    endfunction

    // Driver: present an instruction in ID/EXE and hold it until an edge
    // with stall low consumes it.
    task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r, m, z;
        logic s;
        int n;
        EXE_CMD = cmd;
        val1    = a;
        val2    = b;
        if (cmd == EXE_MUL || cmd == EXE_DIV) begin
            model(cmd, a, b, r, m, z);
            exp_res_q.push_back(r);
            exp_rem_q.push_back(m);
            exp_dbz_q.push_back(z);
        end
        s = 1'b1;
        n = 0;
        while (s && n < 200) begin
            @(negedge clk);
            s = stall;
            @(posedge clk);
            #1;
            n++;
        end
        if (s) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout actual=stalled required=consumed cmd=%h", cmd);
        end
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = W'($urandom_range(0, 40)) - W'(20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (prev_rv && exp_res_q.size() > 0) begin
                check("b2b_gap_stall", W'(stall), W'(1));
            end
            if (result_valid) begin
                if (exp_res_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result actual=%h required=none", result);
                end else begin
                    check("result", result, exp_res_q.pop_front());
                    check("remainder", remainder, exp_rem_q.pop_front());
                    check("div_by_zero", W'(div_by_zero), exp_dbz_q.pop_front());
                    check("stall_in_done", W'(stall), W'(0));
                    check("stall_length", W'(stall_run), W'(W + 1));
                end
            end
            prev_rv = result_valid;
            if (stall) stall_run++;
            else stall_run = 0;
        end else begin
            prev_rv   = 1'b0;
            stall_run = 0;
        end
    end

    // Stimulus
    initial begin
        rst     = 1'b0;
        kill    = 1'b0;
        EXE_CMD = EXE_MUL;
        val1    = 32'd7;
        val2    = 32'hFFFFFFFD;
        #12;
        check("rst_stall", W'(stall), W'(0));
        check("rst_valid", W'(result_valid), W'(0));
        check("rst_result", result, '0);
        check("rst_remainder", remainder, '0);
        check("rst_dbz", W'(div_by_zero), W'(0));
        check("rst_state", W'(dbg_state), W'(MD_IDLE));
        EXE_CMD = EXE_ADD;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // directed cases
        issue(EXE_MUL, 32'd7, 32'hFFFFFFFD);
        issue(EXE_DIV, 32'hFFFFFFEF, 32'd5);
        issue(EXE_DIV, 32'd100, 32'd0);
        issue(EXE_MUL, 32'd3, 32'd4);
        issue(EXE_DIV, 32'd12, 32'd4);
        issue(EXE_ADD, 32'd1, 32'd2);
        issue(EXE_DIV, 32'h80000000, 32'hFFFFFFFF);
        issue(EXE_DIV, 32'h00000011, 32'hFFFFFFFB);

        // kill in BUSY cycle 10
        EXE_CMD = EXE_MUL;
        val1    = 32'd5;
        val2    = 32'd6;
        repeat (11) @(posedge clk);
        #1 kill = 1'b1;
        #1;
        check("kill_stall", W'(stall), W'(0));
        check("kill_valid", W'(result_valid), W'(0));
        @(posedge clk);
        #1;
        kill    = 1'b0;
        EXE_CMD = EXE_ADD;
        #1;
        check("kill_state", W'(dbg_state), W'(MD_IDLE));
        check("kill_add_stall", W'(stall), W'(0));
        issue(EXE_ADD, 32'd9, 32'd9);

        // reset in BUSY cycle 5, op still in ID/EXE afterwards
        EXE_CMD = EXE_MUL;
        val1    = 32'd9;
        val2    = 32'hFFFFFFF5;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_stall", W'(stall), W'(0));
        check("midrst_valid", W'(result_valid), W'(0));
        check("midrst_result", result, '0);
        check("midrst_remainder", remainder, '0);
        check("midrst_dbz", W'(div_by_zero), W'(0));
        check("midrst_state", W'(dbg_state), W'(MD_IDLE));
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        issue(EXE_MUL, 32'd9, 32'hFFFFFFF5);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) issue(EXE_MUL, pick(), pick());
            else if (sel < 8) issue(EXE_DIV, pick(), pick());
            else issue(EXE_ADD, pick(), pick());
        end

        EXE_CMD = EXE_ADD;
        repeat (3) @(posedge clk);
        check("drain", W'(exp_res_q.size()), W'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
